// File: rtl/ws_mmu_feeder_pkg.sv
// Shared constants, FSM state type and lane helper for the weight-stationary MMU feeder.
package ws_mmu_feeder_pkg;

  localparam int unsigned N    = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned ROWW = 8;
  localparam int unsigned CW   = $clog2(N);

  typedef logic [N*DW-1:0] row_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoadWt,
    StStream,
    StDrain,
    StDone
  } feed_state_t;

  function automatic logic [DW-1:0] lane_of(input row_t row, input int unsigned i);
    return row[i*DW +: DW];
  endfunction

endpackage

// File: rtl/ws_mmu_feeder_if.sv
// Handshake and MMU-pin bundle between the feeder and its environment.
interface ws_mmu_feeder_if;
  import ws_mmu_feeder_pkg::*;

  logic            start;
  logic [ROWW-1:0] num_rows;
  logic            wt_valid;
  logic            wt_ready;
  row_t            wt_row;
  logic            act_valid;
  logic            act_ready;
  row_t            act_row;
  logic            control;
  row_t            wt_arr;
  row_t            data_arr;
  logic [N-1:0]    lane_vld;
  logic            busy;
  logic            done;

  modport master (
    output start, num_rows, wt_valid, wt_row, act_valid, act_row,
    input  wt_ready, act_ready, control, wt_arr, data_arr, lane_vld, busy, done
  );

  modport slave (
    input  start, num_rows, wt_valid, wt_row, act_valid, act_row,
    output wt_ready, act_ready, control, wt_arr, data_arr, lane_vld, busy, done
  );

endinterface

// File: rtl/ws_skew_line.sv
// Zero-reset shift register with a valid bit per stage; DEPTH stages of latency.
module ws_skew_line #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  logic [DEPTH-1:0][DW-1:0] data_q;
  logic [DEPTH-1:0]         vld_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q[0] <= din;
      vld_q[0]  <= din_vld;
      for (int k = 1; k < DEPTH; k++) begin
        data_q[k] <= data_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
    end
  end

  assign dout     = data_q[DEPTH-1];
  assign dout_vld = vld_q[DEPTH-1];

endmodule

// File: rtl/ws_mmu_feeder.sv
// Feeds one tile to a weight-stationary MMU: N weight rows with control=1, then
// diagonally skewed activation rows with per-lane valid bits.
module ws_mmu_feeder
  import ws_mmu_feeder_pkg::*;
(
  input logic            clk,
  input logic            reset,
  ws_mmu_feeder_if.slave bus
);

  feed_state_t     state_q;
  logic [ROWW-1:0] num_q;
  logic [ROWW-1:0] cnt_q;
  logic [CW-1:0]   drain_q;
  logic            control_q;
  row_t            wt_arr_q;

  logic         wt_ready;
  logic         act_ready;
  logic         wt_hs;
  logic         act_hs;
  row_t         in_row;
  row_t         data_flat;
  logic [N-1:0] vld_flat;

  assign wt_ready  = (state_q == StLoadWt);
  assign act_ready = (state_q == StStream);
  assign wt_hs     = bus.wt_valid & wt_ready;
  assign act_hs    = bus.act_valid & act_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      num_q     <= '0;
      cnt_q     <= '0;
      drain_q   <= '0;
      control_q <= 1'b0;
      wt_arr_q  <= '0;
    end else begin
      control_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            num_q   <= bus.num_rows;
            cnt_q   <= '0;
            state_q <= StLoadWt;
          end
        end
        StLoadWt: begin
          if (wt_hs) begin
            wt_arr_q  <= bus.wt_row;
            control_q <= 1'b1;
            if (cnt_q == ROWW'(N-1)) begin
              cnt_q <= '0;
              // With no activations the drain only has to cover the skew of the zero diagonals.
              if (num_q == '0) begin
                state_q <= StDrain;
                drain_q <= CW'(N-2);
              end else begin
                state_q <= StStream;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StStream: begin
          if (act_hs) begin
            cnt_q <= cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == num_q) begin
              state_q <= StDrain;
              drain_q <= CW'(N-1);
            end
          end
        end
        StDrain: begin
          if (drain_q == '0) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Cycles without a handshake push a zero bubble down every lane so the MMU never stalls.
  assign in_row = act_hs ? bus.act_row : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    ws_skew_line #(
      .DW    (DW),
      .DEPTH (i + 1)
    ) u_line (
      .clk      (clk),
      .reset    (reset),
      .din      (lane_of(in_row, i)),
      .din_vld  (act_hs),
      .dout     (data_flat[i*DW +: DW]),
      .dout_vld (vld_flat[i])
    );
  end

  assign bus.wt_ready  = wt_ready;
  assign bus.act_ready = act_ready;
  assign bus.control   = control_q;
  assign bus.wt_arr    = wt_arr_q;
  assign bus.data_arr  = data_flat;
  assign bus.lane_vld  = vld_flat;
  assign bus.busy      = (state_q == StLoadWt) || (state_q == StStream) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_ws_mmu_feeder.sv
// Directed bench for ws_mmu_feeder: cycle-timeline model plus hand-computed tile expectations.
module tb_ws_mmu_feeder;
  import ws_mmu_feeder_pkg::*;

  localparam int MAXC = 2048;
  localparam int BIG  = 1 << 30;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ws_mmu_feeder_if bus ();

  ws_mmu_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Timeline model: each accepted transfer schedules its future appearance on the MMU pins.
  bit [N*DW-1:0] e_data [MAXC];
  bit [N-1:0]    e_vld  [MAXC];
  bit            e_ctrl [MAXC];
  bit            e_wup  [MAXC];
  bit [N*DW-1:0] e_wval [MAXC];

  bit            m_active;
  int            m_s, m_wts, m_rows, m_num, m_wlast, m_done;
  bit [N*DW-1:0] m_wt;

  always @(negedge clk) begin : model
    int c;
    bit eb, ed, ewr, ear;
    c = cyc;
    if (c >= MAXC - 8) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", c, MAXC - 8);
      $fatal(1);
    end
    if (reset) begin
      for (int k = c; k < MAXC; k++) begin
        e_data[k] = '0; e_vld[k] = '0; e_ctrl[k] = 0; e_wup[k] = 0; e_wval[k] = '0;
      end
      m_active = 0;
      m_wt     = '0;
    end else if (e_wup[c]) begin
      m_wt = e_wval[c];
    end
    eb  = m_active && c > m_s && c < m_done;
    ed  = m_active && c == m_done;
    ewr = m_active && c > m_s && m_wts < N;
    ear = m_active && m_wts == N && c > m_wlast && m_rows < m_num;
    chk("busy", bus.busy, eb);
    chk("done", bus.done, ed);
    chk("wt_ready", bus.wt_ready, ewr);
    chk("act_ready", bus.act_ready, ear);
    chk("control", bus.control, e_ctrl[c]);
    chk("wt_arr", bus.wt_arr, m_wt);
    chk("data_arr", bus.data_arr, e_data[c]);
    chk("lane_vld", bus.lane_vld, e_vld[c]);
    if (!reset) begin
      if (ewr && bus.wt_valid) begin
        e_ctrl[c+1] = 1;
        e_wup[c+1]  = 1;
        e_wval[c+1] = bus.wt_row;
        m_wts++;
        if (m_wts == N) begin
          m_wlast = c;
          if (m_num == 0) m_done = c + N;
        end
      end
      if (ear && bus.act_valid) begin
        for (int i = 0; i < N; i++) begin
          e_data[c+1+i][i*DW +: DW] = bus.act_row[i*DW +: DW];
          e_vld[c+1+i][i]           = 1'b1;
        end
        m_rows++;
        if (m_rows == m_num) m_done = c + N + 1;
      end
      if (ed) begin
        m_active = 0;
      end else if (!m_active && bus.start) begin
        m_active = 1;
        m_s      = c;
        m_wts    = 0;
        m_rows   = 0;
        m_num    = int'(bus.num_rows);
        m_wlast  = BIG;
        m_done   = BIG;
      end
    end
  end

  // Observation log used by the per-test literal expectations.
  bit           rec = 0;
  logic [31:0]  ctrl_q[$];
  int           ctrl_c[$];
  logic [31:0]  vd_q[$];
  logic [3:0]   vv_q[$];
  int           vc_q[$];
  int           done_cyc;
  int           done_n;
  bit           actr_seen;

  always @(negedge clk) begin
    if (rec) begin
      if (bus.control) begin ctrl_q.push_back(bus.wt_arr); ctrl_c.push_back(cyc); end
      if (|bus.lane_vld) begin
        vd_q.push_back(bus.data_arr); vv_q.push_back(bus.lane_vld); vc_q.push_back(cyc);
      end
      if (bus.done) begin done_cyc = cyc; done_n++; end
      if (bus.act_ready) actr_seen = 1;
    end
  end

  logic [31:0] wts  [4];
  logic [31:0] acts [4];

  task automatic run_tile(input int num, input int wgap_at, input int wgap_len,
                          input int agap_at, input int agap_len, input bit abort);
    int wi, ri, wg, ag;
    bit fin, hw, ha;
    ctrl_q.delete(); ctrl_c.delete(); vd_q.delete(); vv_q.delete(); vc_q.delete();
    done_n = 0; done_cyc = 0; actr_seen = 0; rec = 1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.num_rows = 8'(num);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wi = 0; ri = 0; wg = 0; ag = 0; fin = 0;
    for (int k = 0; k < 100 && !fin; k++) begin
      bus.wt_valid  = (wi < N) && !(wi == wgap_at && wg < wgap_len);
      bus.wt_row    = wts[wi < N ? wi : 0];
      bus.act_valid = (ri < num) && !(ri == agap_at && ag < agap_len);
      bus.act_row   = acts[ri < 4 ? ri : 0];
      @(negedge clk);
      hw = bus.wt_valid && bus.wt_ready;
      ha = bus.act_valid && bus.act_ready;
      if (bus.wt_ready && !bus.wt_valid && wi == wgap_at) wg++;
      if (bus.act_ready && !bus.act_valid && ri == agap_at) ag++;
      if (bus.done) fin = 1;
      @(posedge clk); #1;
      if (hw) wi++;
      if (ha) ri++;
      if (abort && ri == 1) fin = 1;
    end
    if (!abort) begin
      chk("tile_done_seen", fin, 1'b1);
      bus.wt_valid = 0; bus.act_valid = 0;
      repeat (2) @(posedge clk);
      #1 rec = 0;
    end else begin
      // Start while streaming must be ignored; then reset mid-tile.
      bus.start = 1'b1; bus.num_rows = 8'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("rst_async_control", bus.control, 0);
      chk("rst_async_wt_arr", bus.wt_arr, 0);
      chk("rst_async_data_arr", bus.data_arr, 0);
      chk("rst_async_lane_vld", bus.lane_vld, 0);
      chk("rst_async_busy", bus.busy, 0);
      chk("rst_async_act_ready", bus.act_ready, 0);
      bus.wt_valid = 0; bus.act_valid = 0;
      done_n = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("no_done_after_reset", done_n, 0);
      rec = 0;
    end
  endtask

  logic [31:0] exp_d2 [5];
  logic [3:0]  exp_v2 [5];
  logic [31:0] got32;
  logic [3:0]  got4;

  initial begin
    wts  = '{32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403};
    acts = '{32'h04030201, 32'h08070605, 32'h0D0C0B0A, 32'h11223344};
    exp_d2 = '{32'h00000001, 32'h00000205, 32'h00030600, 32'h04070000, 32'h08000000};
    exp_v2 = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    bus.start = 0; bus.num_rows = '0; bus.wt_valid = 0; bus.wt_row = '0;
    bus.act_valid = 0; bus.act_row = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_control", bus.control, 0);
    chk("reset_wt_arr", bus.wt_arr, 0);
    chk("reset_data_arr", bus.data_arr, 0);
    chk("reset_lane_vld", bus.lane_vld, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_ready", {bus.wt_ready, bus.act_ready}, 2'b00);
    #2 reset = 1'b0;

    // Weight load with valid held high, then two-row stream.
    run_tile(2, -1, 0, -1, 0, 0);
    chk("t1_ctrl_count", ctrl_q.size(), 4);
    chk("t1_ctrl_span", (ctrl_c.size() == 4) ? ctrl_c[3] - ctrl_c[0] : -1, 3);
    for (int k = 0; k < 4; k++) begin
      got32 = (k < ctrl_q.size()) ? ctrl_q[k] : '1;
      chk($sformatf("t1_wt_order%0d", k), got32, wts[k]);
    end
    chk("t2_vld_count", vd_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      got32 = (k < vd_q.size()) ? vd_q[k] : '1;
      got4  = (k < vv_q.size()) ? vv_q[k] : '1;
      chk($sformatf("t2_data%0d", k), got32, exp_d2[k]);
      chk($sformatf("t2_vld%0d", k), got4, exp_v2[k]);
    end
    chk("t2_done_after_last", (vc_q.size() > 0) ? done_cyc - vc_q[vc_q.size()-1] : -1, 1);
    chk("t2_done_from_first", (vc_q.size() > 0) ? done_cyc - vc_q[0] : -1, 5);

    // Weight gap of two cycles after row 2.
    run_tile(1, 2, 2, -1, 0, 0);
    chk("t3_ctrl_count", ctrl_q.size(), 4);
    chk("t3_ctrl_span", (ctrl_c.size() == 4) ? ctrl_c[3] - ctrl_c[0] : -1, 5);
    for (int k = 0; k < 4; k++) begin
      got32 = (k < ctrl_q.size()) ? ctrl_q[k] : '1;
      chk($sformatf("t3_wt_order%0d", k), got32, wts[k]);
    end
    chk("t3_done_after_last", (vc_q.size() > 0) ? done_cyc - vc_q[vc_q.size()-1] : -1, 1);

    // One-cycle activation bubble between rows.
    run_tile(2, -1, 0, 1, 1, 0);
    chk("t4_vld_count", vd_q.size(), 6);
    chk("t4_data0", (vd_q.size() > 2) ? vd_q[0] : '1, 32'h00000001);
    chk("t4_vld0", (vv_q.size() > 2) ? vv_q[0] : '1, 4'b0001);
    chk("t4_data1", (vd_q.size() > 2) ? vd_q[1] : '1, 32'h00000200);
    chk("t4_vld1", (vv_q.size() > 2) ? vv_q[1] : '1, 4'b0010);
    chk("t4_data2", (vd_q.size() > 2) ? vd_q[2] : '1, 32'h00030005);
    chk("t4_vld2", (vv_q.size() > 2) ? vv_q[2] : '1, 4'b0101);
    chk("t4_done_from_first", (vc_q.size() > 0) ? done_cyc - vc_q[0] : -1, 6);

    // Empty tile: weights only, short drain.
    run_tile(0, -1, 0, -1, 0, 0);
    chk("t5_ctrl_count", ctrl_q.size(), 4);
    chk("t5_vld_count", vd_q.size(), 0);
    chk("t5_act_ready_seen", actr_seen, 0);
    chk("t5_done_after_ctrl", (ctrl_c.size() > 0) ? done_cyc - ctrl_c[ctrl_c.size()-1] : -1, 3);

    // Start while busy, then reset mid-stream.
    run_tile(3, -1, 0, -1, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
